// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core pipeline.
//   XLEN           datapath width
//   ALU_*          ALU op encodings (000 ADD, 001 SUB, 010 AND, 011 OR;
//                  100-111 reserved and passed through untouched)
//   REG_X0         index of the hard-wired zero register
//   fwd_src_t      one forwarding source (write enable, dest index, value)
//   ex_state_t     registered ID/EX contents
//   fwd_hit()      true when a forwarding source supplies register rs
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic            reg_write;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } fwd_src_t;

   typedef struct packed {
      logic            valid;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [2:0]      alu_ctrl;
      logic            alu_src;
      logic            reg_write;
   } ex_state_t;

   // x0 is never a forwarding target: its value is architecturally 0.
   function automatic logic fwd_hit(input fwd_src_t src, input logic [4:0] rs);
      return src.reg_write && (src.rd != REG_X0) && (src.rd == rs);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundle between decode / hazard / writeback logic and the ID/EX stage.
//   id_*        decoded instruction from the ID slot
//   stall       hold the ID/EX contents (owned by the hazard unit)
//   flush       load a bubble (owned by branch resolution)
//   exmem_*     EX/MEM forwarding source
//   memwb_*     MEM/WB forwarding source
//   ex_*        registered + forwarded values presented to the ALU
// Handshake: there is no valid/ready pair. id_valid marks a real
// instruction in the ID slot; ex_valid marks a real instruction in EX.
// Back-pressure is expressed only through stall, cancellation only
// through flush (flush has priority over stall).
// modport master: the driver of id_*/stall/flush/forwarding (upstream side)
// modport slave : the ID/EX stage itself
// ---------------------------------------------------------------------------
interface id_ex_stage_if;
   import riscv_pkg::*;

   logic            id_valid;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic [4:0]      id_rd;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic [2:0]      id_alu_ctrl;
   logic            id_alu_src;
   logic            id_reg_write;

   logic            stall;
   logic            flush;

   logic            exmem_reg_write;
   logic [4:0]      exmem_rd;
   logic [XLEN-1:0] exmem_result;
   logic            memwb_reg_write;
   logic [4:0]      memwb_rd;
   logic [XLEN-1:0] memwb_wdata;

   logic            ex_valid;
   logic [XLEN-1:0] ex_a;
   logic [XLEN-1:0] ex_b;
   logic [2:0]      ex_alu_ctrl;
   logic [XLEN-1:0] ex_store_data;
   logic [4:0]      ex_rd;
   logic            ex_reg_write;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
             id_imm, id_alu_ctrl, id_alu_src, id_reg_write,
             stall, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_wdata,
      input  ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_store_data, ex_rd,
             ex_reg_write
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
             id_imm, id_alu_ctrl, id_alu_src, id_reg_write,
             stall, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_wdata,
      output ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_store_data, ex_rd,
             ex_reg_write
   );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Operand forwarding selector for one source register.
//   rs        registered source index
//   reg_data  registered register-file read data
//   exmem     EX/MEM forwarding source (youngest, highest priority)
//   memwb     MEM/WB forwarding source
//   data      selected operand value
// ---------------------------------------------------------------------------
module fwd_mux
   import riscv_pkg::*;
(
   input  logic [4:0]      rs,
   input  logic [XLEN-1:0] reg_data,
   input  fwd_src_t        exmem,
   input  fwd_src_t        memwb,
   output logic [XLEN-1:0] data
);

   always_comb begin
      data = reg_data;
      if (fwd_hit(exmem, rs)) begin
         data = exmem.data;
      end else if (fwd_hit(memwb, rs)) begin
         data = memwb.data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with stall, flush and EX/MEM, MEM/WB forwarding.
// Outputs feed the ALU combinationally, so forwarded values reach the ALU
// in the same cycle the forwarding sources present them.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears all state
//   bus    id_ex_stage_if.slave (id_*, stall, flush, forwarding in; ex_* out)
// ---------------------------------------------------------------------------
module id_ex_stage
   import riscv_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   id_ex_stage_if.slave   bus
);

   ex_state_t       st;
   ex_state_t       id_next;
   fwd_src_t        exmem_src;
   fwd_src_t        memwb_src;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   always_comb begin
      id_next           = '0;
      id_next.valid     = bus.id_valid;
      id_next.rs1       = bus.id_rs1;
      id_next.rs2       = bus.id_rs2;
      id_next.rd        = bus.id_rd;
      id_next.rs1_data  = bus.id_rs1_data;
      id_next.rs2_data  = bus.id_rs2_data;
      id_next.imm       = bus.id_imm;
      id_next.alu_ctrl  = bus.id_alu_ctrl;
      id_next.alu_src   = bus.id_alu_src;
      id_next.reg_write = bus.id_reg_write;
   end

   // A flushed bubble clears every field, so rs1/rs2 become x0 and the
   // bubble can never pick up a forwarded value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= '0;
      end else if (bus.flush) begin
         st <= '0;
      end else if (!bus.stall) begin
         st <= id_next;
      end
   end

   always_comb begin
      exmem_src           = '0;
      exmem_src.reg_write = bus.exmem_reg_write;
      exmem_src.rd        = bus.exmem_rd;
      exmem_src.data      = bus.exmem_result;
      memwb_src           = '0;
      memwb_src.reg_write = bus.memwb_reg_write;
      memwb_src.rd        = bus.memwb_rd;
      memwb_src.data      = bus.memwb_wdata;
   end

   fwd_mux u_fwd_rs1 (
      .rs       (st.rs1),
      .reg_data (st.rs1_data),
      .exmem    (exmem_src),
      .memwb    (memwb_src),
      .data     (rs1_fwd)
   );

   fwd_mux u_fwd_rs2 (
      .rs       (st.rs2),
      .reg_data (st.rs2_data),
      .exmem    (exmem_src),
      .memwb    (memwb_src),
      .data     (rs2_fwd)
   );

   assign bus.ex_valid      = st.valid;
   assign bus.ex_a          = rs1_fwd;
   assign bus.ex_b          = st.alu_src ? st.imm : rs2_fwd;
   assign bus.ex_alu_ctrl   = st.alu_ctrl;
   assign bus.ex_store_data = rs2_fwd;
   assign bus.ex_rd         = st.rd;
   assign bus.ex_reg_write  = st.reg_write & st.valid;

endmodule
